// File: rtl/status_bank.sv
// Game-board register file: holds N 4-bit digit cells, commits the adder result on enable release.
// Optional single-level undo is enabled by defining STATUS_BANK_UNDO_EN.
module status_bank #(
  parameter int unsigned         N           = 10,
  parameter logic [N*4-1:0]      INIT_STATUS = {N{4'd1}},
  parameter int unsigned         CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [3:0]         values,
  input  logic [3:0]         selected_index,
`ifdef STATUS_BANK_UNDO_EN
  input  logic               undo,
`endif
  output logic [N*4-1:0]     status,
  output logic               commit_ok,
  output logic               commit_err,
  output logic [CNT_W-1:0]   move_count,
  output logic               board_clear,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;

  localparam logic [4:0] N_L          = 5'(N);
  localparam logic       W_INIT_CLEAR = (INIT_STATUS == '0);

  state_t             r_state;
  logic [N*4-1:0]     r_status;
  logic [3:0]         r_val;
  logic [3:0]         r_idx;
  logic               r_ok;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_clear;

  logic               w_valid;
  logic               w_all_zero;
  logic [3:0]         w_prev;

`ifdef STATUS_BANK_UNDO_EN
  logic               r_undo_q;
  logic               r_undo_valid;
  logic [3:0]         r_u_idx;
  logic [3:0]         r_u_val;
  logic               w_undo_go;

  assign w_undo_go = (r_state == IDLE) && undo && !r_undo_q && r_undo_valid;
`endif

  // w_prev is the cell about to be overwritten, kept for undo
  always_comb begin
    w_valid    = ({1'b0, r_idx} < N_L) && (r_val <= 4'd9);
    w_all_zero = 1'b1;
    w_prev     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (r_status[i*4 +: 4] != 4'd0) w_all_zero = 1'b0;
      if (r_idx == 4'(i))             w_prev     = r_status[i*4 +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_status <= INIT_STATUS;
      r_val    <= '0;
      r_idx    <= '0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_clear  <= W_INIT_CLEAR;
`ifdef STATUS_BANK_UNDO_EN
      r_undo_q     <= 1'b0;
      r_undo_valid <= 1'b0;
      r_u_idx      <= '0;
      r_u_val      <= '0;
`endif
    end else begin
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_clear <= w_all_zero;
      case (r_state)
        IDLE: begin
          if (enable) r_state <= ARMED;
        end
        ARMED: begin
          if (!enable) begin
            r_val   <= values;
            r_idx   <= selected_index;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_state <= IDLE;
          if (w_valid) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (r_idx == 4'(i)) r_status[i*4 +: 4] <= r_val;
            end
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            r_ok <= 1'b1;
`ifdef STATUS_BANK_UNDO_EN
            r_u_idx      <= r_idx;
            r_u_val      <= w_prev;
            r_undo_valid <= 1'b1;
`endif
          end else begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
`ifdef STATUS_BANK_UNDO_EN
      r_undo_q <= undo;
      // Undo only fires from IDLE, so it never collides with a WRITE commit
      if (w_undo_go) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (r_u_idx == 4'(i)) r_status[i*4 +: 4] <= r_u_val;
        end
        if (r_cnt != '0 && r_cnt != '1) r_cnt <= r_cnt - CNT_W'(1);
        r_undo_valid <= 1'b0;
        r_ok         <= 1'b1;
      end
`endif
    end
  end

  assign status      = r_status;
  assign commit_ok   = r_ok;
  assign commit_err  = r_err;
  assign move_count  = r_cnt;
  assign board_clear = r_clear;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_status_bank.sv
// Scoreboard bench for status_bank: stimulus pushes expected commit results, a monitor checks pulses.
// Undo stimulus is included when STATUS_BANK_UNDO_EN is defined.
module tb_status_bank;

  localparam int unsigned N     = 10;
  localparam int unsigned CNT_W = 8;
  localparam logic [N*4-1:0] INIT = {N{4'd1}};

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [3:0]       values;
  logic [3:0]       selected_index;
  logic [N*4-1:0]   status;
  logic             commit_ok;
  logic             commit_err;
  logic [CNT_W-1:0] move_count;
  logic             board_clear;
  logic             busy;
`ifdef STATUS_BANK_UNDO_EN
  logic             undo = 1'b0;
`endif

  status_bank #(.N(N), .INIT_STATUS(INIT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .values         (values),
    .selected_index (selected_index),
`ifdef STATUS_BANK_UNDO_EN
    .undo           (undo),
`endif
    .status         (status),
    .commit_ok      (commit_ok),
    .commit_err     (commit_err),
    .move_count     (move_count),
    .board_clear    (board_clear),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           ok;
    logic [N*4-1:0] st;
    int             cnt;
    string          name;
  } exp_t;

  exp_t           sb[$];
  int             errors = 0;
  int             checks = 0;
  logic [N*4-1:0] m_status;
  int             m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (commit_ok || commit_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse: got ok=%0b err=%0b expected no pulse", commit_ok, commit_err);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_kind"}, {62'd0, commit_ok, commit_err}, e.ok ? 64'd2 : 64'd1);
        chk({e.name, "_status"}, 64'(status), 64'(e.st));
        chk({e.name, "_count"}, 64'(move_count), 64'(e.cnt));
      end
    end
  end

  function automatic void push_exp(input logic ok, input string nm);
    exp_t e;
    e.ok = ok; e.st = m_status; e.cnt = m_cnt; e.name = nm;
    sb.push_back(e);
  endfunction

  // Holds enable high for 'hold' cycles, releases with operands, optionally alters values afterwards.
  task automatic do_commit(input logic [3:0] v, input logic [3:0] idx, input int hold,
                           input logic late_chg, input string nm,
                           output logic bc1, output logic bc2);
    int  ii;
    logic ok;
    @(negedge clk) enable = 1'b1;
    repeat (hold) @(negedge clk);
    chk({nm, "_busy_armed"}, 64'(busy), 64'd1);
    enable = 1'b0; values = v; selected_index = idx;
    ii = int'(idx);
    ok = (ii < N) && (v <= 4'd9);
    if (ok) begin
      m_status[ii*4 +: 4] = v;
      if (m_cnt != 255) m_cnt++;
    end
    push_exp(ok, nm);
    @(negedge clk);
    if (late_chg) begin values = 4'd5; selected_index = 4'd8; end
    @(negedge clk); bc1 = board_clear;
    @(negedge clk); bc2 = board_clear;
    @(negedge clk);
    chk({nm, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_status"}, 64'(status), 64'(INIT));
    chk({nm, "_count"},  64'(move_count), 64'd0);
    chk({nm, "_pulses"}, {62'd0, commit_ok, commit_err}, 64'd0);
    chk({nm, "_busy"},   64'(busy), 64'd0);
    chk({nm, "_clear"},  64'(board_clear), 64'd0);
  endtask

  initial begin
    logic b1, b2;
    rst = 1'b1; enable = 1'b0; values = '0; selected_index = 4'hF;
    m_status = INIT; m_cnt = 0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    do_commit(4'd7, 4'd3, 5, 1'b0, "valid_c3", b1, b2);
    do_commit(4'd2, 4'hF, 2, 1'b0, "rej_nosel", b1, b2);
    do_commit(4'hC, 4'd0, 2, 1'b0, "rej_val", b1, b2);
    do_commit(4'd3, 4'd12, 2, 1'b0, "rej_idx", b1, b2);
    do_commit(4'd3, 4'd4, 1, 1'b1, "capture", b1, b2);

    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    m_status = INIT; m_cnt = 0;

    for (int i = 0; i < 10; i++) begin
      if (i == 9) chk("clear_before_last", 64'(board_clear), 64'd0);
      do_commit(4'd0, 4'(i), 1, 1'b0, "zero", b1, b2);
    end
    chk("clear_k1", 64'(b1), 64'd0);
    chk("clear_k2", 64'(b2), 64'd1);
    chk("clear_hold", 64'(board_clear), 64'd1);

    @(negedge clk) enable = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_busy", 64'(busy), 64'd1);
    chk("held_status", 64'(status), 64'(m_status));
    enable = 1'b0; selected_index = 4'hF; values = 4'd1;
    push_exp(1'b0, "held_release");
    repeat (4) @(negedge clk);

    @(negedge clk) enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0; values = 4'd9; selected_index = 4'd1;
    @(posedge clk);
    #1 rst = 1'b1;
    m_status = INIT; m_cnt = 0;
    @(negedge clk);
    check_reset_state("rst_write");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_write_after", 64'(status), 64'(INIT));

`ifdef STATUS_BANK_UNDO_EN
    do_commit(4'd9, 4'd2, 2, 1'b0, "undo_pre", b1, b2);
    @(negedge clk) undo = 1'b1;
    m_status[2*4 +: 4] = 4'd1;
    m_cnt = 0;
    push_exp(1'b1, "undo1");
    repeat (3) @(negedge clk);
    undo = 1'b0;
    repeat (2) @(negedge clk);
    undo = 1'b1;
    repeat (3) @(negedge clk);
    undo = 1'b0;
    chk("undo2_status", 64'(status), 64'(INIT));
    chk("undo2_count", 64'(move_count), 64'd0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
